// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write arbiter: FSM state encoding and an index helper.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1
  } arb_state_e;

  // Successor of idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set request at or after start, wrapping around.
module rr_pick #(
  parameter int NUM_REQ   = 3,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] start,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] idx
);

  // Walk the ring from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int k;
      k = (int'(start) + i) % NUM_REQ;
      if (req[k]) begin
        found = 1'b1;
        idx   = IDX_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 17,
  parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_n,
  input  logic [NUM_REQ-1:0]            i_Req_Valid,
  input  logic [NUM_REQ-1:0]            i_Req_Last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_Req_Data,
  output logic [NUM_REQ-1:0]            o_Req_Ready,
  input  logic                          i_Full,
  output logic                          o_Data_Valid,
  output logic [DATA_WIDTH-1:0]         o_Data,
  output logic [1:0]                    o_Diag_State,
  output logic [IDX_WIDTH-1:0]          o_Diag_Grant
);

  arb_state_e           state, next_state;
  logic [IDX_WIDTH-1:0] grant, next_grant;
  logic [IDX_WIDTH-1:0] start_idx;
  logic                 pick_found;
  logic [IDX_WIDTH-1:0] pick_idx;

  // The just-served requester always gets lowest priority.
  assign start_idx = IDX_WIDTH'(wrap_inc(int'(grant), NUM_REQ));

  rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr_pick (
    .req   (i_Req_Valid),
    .start (start_idx),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= ST_IDLE;
      grant <= IDX_WIDTH'(NUM_REQ - 1);
    end else begin
      state <= next_state;
      grant <= next_grant;
    end
  end

  always_comb begin
    next_state   = state;
    next_grant   = grant;
    o_Data_Valid = 1'b0;
    o_Req_Ready  = '0;
    o_Data       = '0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          next_state = ST_LOCKED;
          next_grant = pick_idx;
        end
      end
      ST_LOCKED: begin
        o_Data_Valid = i_Req_Valid[grant] & ~i_Full;
        if (o_Data_Valid) begin
          o_Req_Ready[grant] = 1'b1;
          o_Data             = i_Req_Data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
          // End of packet: re-arbitrate immediately, the finishing requester included.
          if (i_Req_Last[grant]) begin
            if (pick_found) begin
              next_grant = pick_idx;
            end else begin
              next_state = ST_IDLE;
            end
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  assign o_Diag_State = state;
  assign o_Diag_Grant = grant;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: per-requester packet queues drive the DUT, a ring-arbitration model predicts outputs.
module tb_fifo_wr_arbiter;

  localparam int NR = 3;
  localparam int DW = 17;
  localparam int IW = 2;

  typedef struct {
    logic          last;
    logic [DW-1:0] data;
  } word_t;

  logic             i_Clk = 1'b0;
  logic             i_Rst_n = 1'b1;
  logic [NR-1:0]    i_Req_Valid = '0;
  logic [NR-1:0]    i_Req_Last = '0;
  logic [NR*DW-1:0] i_Req_Data = '0;
  logic [NR-1:0]    o_Req_Ready;
  logic             i_Full = 1'b0;
  logic             o_Data_Valid;
  logic [DW-1:0]    o_Data;
  logic [1:0]       o_Diag_State;
  logic [IW-1:0]    o_Diag_Grant;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .i_Clk        (i_Clk),
    .i_Rst_n      (i_Rst_n),
    .i_Req_Valid  (i_Req_Valid),
    .i_Req_Last   (i_Req_Last),
    .i_Req_Data   (i_Req_Data),
    .o_Req_Ready  (o_Req_Ready),
    .i_Full       (i_Full),
    .o_Data_Valid (o_Data_Valid),
    .o_Data       (o_Data),
    .o_Diag_State (o_Diag_State),
    .o_Diag_Grant (o_Diag_Grant)
  );

  always #5 i_Clk = ~i_Clk;

  word_t         q [NR][$];
  logic [DW-1:0] got [$];
  int            got_cyc [$];
  logic [DW-1:0] exp_q [$];
  int            exp_c [$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic          full_in = 1'b0;
  bit            m_locked = 1'b0;
  int            m_grant = NR - 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next grant: first valid requester after g, going round the ring, g itself last.
  function automatic int rr_next(input logic [NR-1:0] v, input int g);
    for (int i = 1; i <= NR; i++) begin
      if (v[(g + i) % NR]) return (g + i) % NR;
    end
    return g;
  endfunction

  task automatic push_word(input int k, input logic [DW-1:0] d, input logic last);
    word_t w;
    w.data = d;
    w.last = last;
    q[k].push_back(w);
  endtask

  task automatic applyStimulus();
    logic [NR-1:0]    v, l;
    logic [NR*DW-1:0] d;
    logic             exp_dv;
    logic [NR-1:0]    exp_rdy;
    logic [DW-1:0]    exp_data;
    logic             fin;
    v = '0; l = '0; d = '0;
    for (int k = 0; k < NR; k++) begin
      if (q[k].size() > 0) begin
        v[k] = 1'b1;
        l[k] = q[k][0].last;
        d[k*DW +: DW] = q[k][0].data;
      end
    end
    i_Req_Valid = v;
    i_Req_Last  = l;
    i_Req_Data  = d;
    i_Full      = full_in;
    #4;
    exp_dv   = m_locked && v[m_grant] && !full_in;
    exp_rdy  = exp_dv ? NR'(1 << m_grant) : '0;
    exp_data = exp_dv ? q[m_grant][0].data : '0;
    chk("ready", 32'(o_Req_Ready), 32'(exp_rdy));
    chk("data_valid", 32'(o_Data_Valid), 32'(exp_dv));
    chk("data", 32'(o_Data), 32'(exp_data));
    chk("diag_state", 32'(o_Diag_State), m_locked ? 32'd1 : 32'd0);
    chk("diag_grant", 32'(o_Diag_Grant), 32'(m_grant));
    if (o_Data_Valid === 1'b1) begin
      got.push_back(o_Data);
      got_cyc.push_back(cyc);
    end
    if (!m_locked) begin
      if (v != '0) begin
        m_locked = 1'b1;
        m_grant  = rr_next(v, m_grant);
      end
    end else if (exp_dv) begin
      fin = q[m_grant][0].last;
      void'(q[m_grant].pop_front());
      if (fin) begin
        if (v != '0) m_grant = rr_next(v, m_grant);
        else m_locked = 1'b0;
      end
    end
    cyc++;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic applyReset();
    i_Rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(o_Data_Valid), 32'd0);
    chk("rst_ready", 32'(o_Req_Ready), 32'd0);
    chk("rst_data", 32'(o_Data), 32'd0);
    chk("rst_state", 32'(o_Diag_State), 32'd0);
    chk("rst_grant", 32'(o_Diag_Grant), 32'd2);
    for (int k = 0; k < NR; k++) q[k].delete();
    i_Req_Valid = '0;
    i_Req_Last  = '0;
    i_Req_Data  = '0;
    full_in     = 1'b0;
    i_Full      = 1'b0;
    m_locked    = 1'b0;
    m_grant     = NR - 1;
    @(posedge i_Clk);
    #1;
    i_Rst_n = 1'b1;
    got.delete();
    got_cyc.delete();
    exp_q.delete();
    exp_c.delete();
    cyc = 0;
  endtask

  // Compares the captured write log against the expected word/cycle lists.
  task automatic checkOutput(input string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk({tag, "_word"}, 32'(got[i]), 32'(exp_q[i]));
      chk({tag, "_cycle"}, 32'(got_cyc[i]), 32'(exp_c[i]));
    end
  endtask

  initial begin
    #1;
    applyReset();
    run(2);

    applyReset();
    push_word(0, 17'h00001, 1'b1);
    push_word(1, 17'h00002, 1'b1);
    push_word(2, 17'h00003, 1'b1);
    run(6);
    exp_q = '{17'h1, 17'h2, 17'h3};
    exp_c = '{1, 2, 3};
    checkOutput("three_way");

    applyReset();
    push_word(0, 17'h10, 1'b0);
    push_word(0, 17'h11, 1'b0);
    push_word(0, 17'h12, 1'b1);
    push_word(1, 17'h20, 1'b1);
    run(7);
    exp_q = '{17'h10, 17'h11, 17'h12, 17'h20};
    exp_c = '{1, 2, 3, 4};
    checkOutput("no_interleave");

    applyReset();
    push_word(0, 17'h10, 1'b0);
    push_word(0, 17'h11, 1'b0);
    push_word(0, 17'h12, 1'b1);
    for (int c = 0; c < 10; c++) begin
      full_in = (c >= 2 && c <= 6);
      applyStimulus();
    end
    exp_q = '{17'h10, 17'h11, 17'h12};
    exp_c = '{1, 7, 8};
    checkOutput("full_stall");

    applyReset();
    push_word(2, 17'h5, 1'b1);
    push_word(2, 17'h6, 1'b1);
    run(5);
    exp_q = '{17'h5, 17'h6};
    exp_c = '{1, 2};
    checkOutput("regrant");

    applyReset();
    push_word(1, 17'h30, 1'b0);
    push_word(1, 17'h31, 1'b0);
    push_word(1, 17'h32, 1'b1);
    run(2);
    applyReset();
    push_word(0, 17'h40, 1'b1);
    push_word(1, 17'h41, 1'b1);
    run(5);
    exp_q = '{17'h40, 17'h41};
    exp_c = '{1, 2};
    checkOutput("after_reset");

    applyReset();
    for (int c = 0; c < 400; c++) begin
      int k;
      k = $urandom_range(0, NR - 1);
      if (q[k].size() == 0 && $urandom_range(0, 2) == 0) begin
        int len;
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++)
          push_word(k, DW'($urandom), (j == len - 1));
      end
      full_in = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
